// File: rtl/xctcmsg_piton_noc_tx_arb.sv
// Round-robin transmit arbiter and flit serializer for one OpenPiton NoC output port.
// Optional: define XCTCMSG_NOC_TX_LENGTH_FORCE_EN to overwrite the header length field on latch.
module xctcmsg_piton_noc_tx_arb #(
   parameter int NUM_REQ       = 2,
   parameter int FLIT_WIDTH    = 64,
   parameter int PAYLOAD_FLITS = 2,
   localparam int NOC_WIDTH    = FLIT_WIDTH * (PAYLOAD_FLITS + 1),
   localparam int ID_W         = $clog2(NUM_REQ),
   localparam int CNT_W        = $clog2(PAYLOAD_FLITS + 1)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NUM_REQ-1:0]                  req_valid_i,
   output logic [NUM_REQ-1:0]                  req_ready_o,
   input  logic [NUM_REQ-1:0][NOC_WIDTH-1:0]   req_msg_i,
   output logic                                noc_valid_o,
   input  logic                                noc_ready_i,
   output logic [FLIT_WIDTH-1:0]               noc_data_o,
   output logic [ID_W-1:0]                     grant_id_o,
   output logic                                busy_o
);

   // Message layout: header in the top flit, payload below it with the low word first on the wire.
   localparam int HDR_LSB = NOC_WIDTH - FLIT_WIDTH;
   localparam int LEN_LSB = HDR_LSB + 22;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_FLITS);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]        grant_id_q, grant_id_d;
   logic [CNT_W-1:0]       flit_cnt_q, flit_cnt_d;
   logic [NOC_WIDTH-1:0]   msg_q, msg_d;
   logic                   msg_load;
   logic                   found;
   logic [ID_W-1:0]        winner;
   logic [NUM_REQ-1:0]     ready_onehot;
   logic [FLIT_WIDTH-1:0]  flit_data;

   // Two passes give the rotating priority: indices above rr_ptr first, then wrap to 0..rr_ptr.
   always_comb begin
      found        = 1'b0;
      winner       = '0;
      ready_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && (i > int'(rr_ptr_q)) && req_valid_i[i]) begin
            found  = 1'b1;
            winner = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && (i <= int'(rr_ptr_q)) && req_valid_i[i]) begin
            found  = 1'b1;
            winner = ID_W'(i);
         end
      end
      if (found) begin
         ready_onehot[winner] = 1'b1;
      end
   end

   always_comb begin
      flit_data = msg_q[HDR_LSB +: FLIT_WIDTH];
      for (int k = 1; k <= PAYLOAD_FLITS; k++) begin
         if (flit_cnt_q == CNT_W'(k)) begin
            flit_data = msg_q[(k-1)*FLIT_WIDTH +: FLIT_WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      flit_cnt_d  = flit_cnt_q;
      msg_load    = 1'b0;
      req_ready_o = '0;
      noc_valid_o = 1'b0;
      noc_data_o  = '0;
      busy_o      = 1'b0;
      case (state_q)
         IDLE: begin
            // Masked during reset so no requester sees an accept that the flops will ignore.
            if (!rst_i) begin
               req_ready_o = ready_onehot;
            end
            if (found) begin
               msg_load   = 1'b1;
               rr_ptr_d   = winner;
               grant_id_d = winner;
               flit_cnt_d = '0;
               state_d    = SEND;
            end
         end
         SEND: begin
            noc_valid_o = 1'b1;
            busy_o      = 1'b1;
            noc_data_o  = flit_data;
            if (noc_ready_i) begin
               if (flit_cnt_q == LAST_CNT) begin
                  flit_cnt_d = '0;
                  state_d    = IDLE;
               end else begin
                  flit_cnt_d = flit_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      msg_d = msg_q;
      if (msg_load) begin
         msg_d = req_msg_i[winner];
`ifdef XCTCMSG_NOC_TX_LENGTH_FORCE_EN
         msg_d[LEN_LSB +: 8] = 8'(PAYLOAD_FLITS);
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rr_ptr_q   <= ID_W'(NUM_REQ - 1);
         grant_id_q <= '0;
         flit_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         flit_cnt_q <= flit_cnt_d;
      end
   end

   // Message holding register carries no reset; it is only observable while in SEND.
   always_ff @(posedge clk_i) begin
      msg_q <= msg_d;
   end

   assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_xctcmsg_piton_noc_tx_arb.sv
// Self-checking bench for xctcmsg_piton_noc_tx_arb: table-driven arbitration vectors with a
// flit scoreboard, plus hand-written sequences for mid-packet reset and a 4-requester instance.
module tb_xctcmsg_piton_noc_tx_arb;

   localparam int NF = 3;

   logic clk = 1'b0;
   logic rst_i;
   always #5 clk = ~clk;

   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [1:0][191:0]  req_msg;
   logic               noc_valid, noc_ready, busy;
   logic [63:0]        noc_data;
   logic [0:0]         grant;

   logic [3:0]         req_valid4;
   logic [3:0]         req_ready4;
   logic [3:0][191:0]  req_msg4;
   logic               noc_valid4, busy4;
   logic [63:0]        noc_data4;
   logic [1:0]         grant4;

   xctcmsg_piton_noc_tx_arb dut (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_msg_i(req_msg), .noc_valid_o(noc_valid), .noc_ready_i(noc_ready),
      .noc_data_o(noc_data), .grant_id_o(grant), .busy_o(busy));

   xctcmsg_piton_noc_tx_arb #(.NUM_REQ(4)) dut4 (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid4), .req_ready_o(req_ready4),
      .req_msg_i(req_msg4), .noc_valid_o(noc_valid4), .noc_ready_i(1'b1),
      .noc_data_o(noc_data4), .grant_id_o(grant4), .busy_o(busy4));

   typedef struct {
      logic [1:0] valid;
      logic [1:0] exp_ready;
      int         stall_flit;
      int         stall_len;
   } vec_t;

   typedef struct {
      logic [0:0]  gid;
      logic [63:0] data;
   } flit_t;

   flit_t sb[$];
   int    serial[2];
   int    n_vec = 0;
   int    n_err = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [191:0] make_msg(input int i, input int s);
      logic [63:0] hdr, lo, hi;
      if (i == 0 && s == 0)
         return {64'h0000_0400_0080_0000, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      hdr = {14'(i + 1), 8'(s + 1), 8'(s * 2 + 1), 4'(i), 8'h05, 22'(s * 3 + i + 1)};
      lo  = {32'hA5A5_0000 + 32'(i), 32'(s)};
      hi  = {32'h5A5A_0000 + 32'(s), 32'(i + 16)};
      return {hdr, hi, lo};
   endfunction

   function automatic logic [63:0] exp_hdr(input logic [63:0] h);
      logic [63:0] r;
      r = h;
`ifdef XCTCMSG_NOC_TX_LENGTH_FORCE_EN
      r[29:22] = 8'h02;
`endif
      return r;
   endfunction

   task automatic push_msg(input int w, input logic [191:0] m);
      flit_t f;
      f.gid = 1'(w);
      f.data = exp_hdr(m[191:128]); sb.push_back(f);
      f.data = m[63:0];             sb.push_back(f);
      f.data = m[127:64];           sb.push_back(f);
   endtask

   // Entered just after a rising edge; leaves just after the rising edge that ends the message.
   task automatic apply(input vec_t v);
      int w, cyc, k, st;
      req_valid = v.valid;
      @(negedge clk);
      chk("idle_busy", 256'(busy), 256'(0));
      chk("req_ready", 256'(req_ready), 256'(v.exp_ready));
      if (v.exp_ready == 2'b00) begin
         @(posedge clk); #1;
         return;
      end
      w = v.exp_ready[1] ? 1 : 0;
      push_msg(w, req_msg[w]);
      serial[w]++;
      @(posedge clk); #1;
      req_msg[w] = make_msg(w, serial[w]);
      cyc = 0; k = 0; st = 0;
      while (sb.size() != 0 && cyc < 40) begin
         @(negedge clk);
         noc_ready = !(k == v.stall_flit && st < v.stall_len);
         chk("flit", 256'({noc_valid, busy, grant, noc_data}),
             256'({1'b1, 1'b1, sb[0].gid, sb[0].data}));
         chk("flit_cnt", 256'(dut.flit_cnt_q), 256'(k));
         if (noc_ready) begin
            void'(sb.pop_front());
            k++;
         end else begin
            st++;
         end
         cyc++;
         @(posedge clk); #1;
      end
      chk("send_cycles", 256'(cyc), 256'(NF + v.stall_len));
      sb.delete();
      noc_ready = 1'b1;
   endtask

   task automatic apply4(input logic [3:0] v, input logic [3:0] exp_ready, input int w);
      logic [191:0] m;
      req_valid4 = v;
      @(negedge clk);
      chk("req_ready4", 256'(req_ready4), 256'(exp_ready));
      m = req_msg4[w];
      @(posedge clk); #1;
      @(negedge clk);
      chk("hdr4", 256'({noc_valid4, busy4, grant4, noc_data4}),
          256'({1'b1, 1'b1, 2'(w), exp_hdr(m[191:128])}));
      repeat (NF) @(posedge clk);
      #1;
   endtask

   vec_t tbl[11];

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{2'b01, 2'b01, 9, 0};   // test-plan single message
      tbl[1]  = '{2'b11, 2'b10, 9, 0};   // both valid: rotation 1,0,1
      tbl[2]  = '{2'b11, 2'b01, 9, 0};
      tbl[3]  = '{2'b11, 2'b10, 9, 0};
      tbl[4]  = '{2'b11, 2'b01, 1, 5};   // 5-cycle stall on payload flit 1
      tbl[5]  = '{2'b10, 2'b10, 9, 0};   // sole requester re-granted
      tbl[6]  = '{2'b10, 2'b10, 9, 0};
      tbl[7]  = '{2'b01, 2'b01, 0, 2};   // stall on header flit
      tbl[8]  = '{2'b01, 2'b01, 9, 0};
      tbl[9]  = '{2'b00, 2'b00, 9, 0};   // nobody valid
      tbl[10] = '{2'b11, 2'b10, 2, 3};   // stall on last flit

      serial[0] = 0; serial[1] = 0;
      for (int i = 0; i < 2; i++) req_msg[i] = make_msg(i, 0);
      for (int i = 0; i < 4; i++) req_msg4[i] = make_msg(i, 0);
      req_valid = '0; req_valid4 = '0; noc_ready = 1'b1;
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out", 256'({noc_valid, busy, req_ready, grant, noc_data}), 256'(0));
      chk("reset_cnt", 256'({dut.flit_cnt_q, dut.rr_ptr_q}), 256'({2'b00, 1'b1}));
      @(posedge clk); #1;
      rst_i = 1'b0;

      for (int t = 0; t < 11; t++) apply(tbl[t]);

      // Mid-packet reset: requester 0 wins (rr=1), reset lands during payload flit 1.
      req_valid = 2'b11;
      @(negedge clk);
      chk("rst_pre_ready", 256'(req_ready), 256'(2'b01));
      serial[0]++;
      @(posedge clk); #1;
      req_msg[0] = make_msg(0, serial[0]);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_pre_cnt", 256'({noc_valid, dut.flit_cnt_q}), 256'({1'b1, 2'd1}));
      #2 rst_i = 1'b1;
      #1 chk("rst_async", 256'({noc_valid, busy, req_ready, grant, noc_data}), 256'(0));
      @(posedge clk); #1;
      chk("rst_held", 256'({noc_valid, busy, req_ready, noc_data}), 256'(0));
      rst_i = 1'b0;
      // rr was 0 before reset; requester 0 winning proves rr returned to NUM_REQ-1.
      apply('{2'b11, 2'b01, 9, 0});
      apply('{2'b11, 2'b10, 9, 0});
      req_valid = 2'b00;

      // Four-requester instance: bring rr to 1, then 1 and 3 valid -> 3 then 1.
      apply4(4'b0010, 4'b0010, 1);
      apply4(4'b1010, 4'b1000, 3);
      apply4(4'b1010, 4'b0010, 1);
      req_valid4 = 4'b0000;
      @(negedge clk);
      chk("idle4", 256'({busy4, noc_valid4, req_ready4}), 256'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
